// File: rtl/serial_sum_collector_if.sv
// Signal bundle between the serial adder and the sum collector.
// master drives the serial bits and the consumer controls; slave is the collector.
interface serial_sum_collector_if #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
);
    logic               bit_in;
    logic               bit_valid;
    logic               first;
    logic               carry_in;
    logic               res_ready;
    logic               clr_err;
    logic [WIDTH-1:0]   res_data;
    logic               res_carry;
    logic               res_valid;
    logic               busy;
    logic               frame_err;
    logic               overrun;
    logic [COUNT_W-1:0] word_count;

    modport master (
        output bit_in, bit_valid, first, carry_in, res_ready, clr_err,
        input  res_data, res_carry, res_valid, busy, frame_err, overrun, word_count
    );

    modport slave (
        input  bit_in, bit_valid, first, carry_in, res_ready, clr_err,
        output res_data, res_carry, res_valid, busy, frame_err, overrun, word_count
    );
endinterface

// File: rtl/serial_sum_collector.sv
// Deserializes LSB-first sum bits plus the final carry into a WIDTH-bit word
// held in a one-deep valid/ready output register; assembly continues behind it.
module serial_sum_collector #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_sum_collector_if.slave bus
);
    localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt, idx_base;
    logic [WIDTH-1:0]   sreg, shifted;
    logic [WIDTH-1:0]   res_data_q;
    logic               res_carry_q, res_valid_q, frame_err_q, overrun_q;
    logic [COUNT_W-1:0] word_count_q;
    logic               accept, done, load, handoff, ferr_evt, ovr_evt;

    // New bit enters at the MSB so after WIDTH shifts bit k sits at position k.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shifted = bus.bit_in;
        end else begin : g_wn
            assign shifted = {bus.bit_in, sreg[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        idx_base  = idx;
        accept    = 1'b0;
        ferr_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.bit_valid) begin
                    if (bus.first) begin
                        accept   = 1'b1;
                        idx_base = '0;
                    end else begin
                        ferr_evt = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (bus.bit_valid) begin
                    accept = 1'b1;
                    // A premature first abandons the partial word and restarts.
                    if (bus.first) begin
                        ferr_evt = 1'b1;
                        idx_base = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        done = accept && (idx_base == LAST_IDX);
        if (accept) begin
            if (done) begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end else begin
                state_nxt = SHIFT;
                idx_nxt   = idx_base + IDX_W'(1);
            end
        end
        handoff = res_valid_q & bus.res_ready;
        load    = done & (~res_valid_q | bus.res_ready);
        ovr_evt = done & res_valid_q & ~bus.res_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            sreg         <= '0;
            res_data_q   <= '0;
            res_carry_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            word_count_q <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (accept) begin
                sreg <= shifted;
            end
            if (load) begin
                res_data_q  <= shifted;
                res_carry_q <= bus.carry_in;
                res_valid_q <= 1'b1;
            end else if (handoff) begin
                res_valid_q <= 1'b0;
            end
            if (handoff) begin
                word_count_q <= word_count_q + COUNT_W'(1);
            end
            // A same-cycle error event takes precedence over the clear.
            frame_err_q <= ferr_evt | (frame_err_q & ~bus.clr_err);
            overrun_q   <= ovr_evt  | (overrun_q   & ~bus.clr_err);
        end
    end

    assign bus.res_data   = res_data_q;
    assign bus.res_carry  = res_carry_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.busy       = (state == SHIFT);
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_serial_sum_collector.sv
// Bench for serial_sum_collector: directed scenarios plus random traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_serial_sum_collector;
    localparam int W  = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_sum_collector_if #(.WIDTH(W), .COUNT_W(CW)) bus();
    serial_sum_collector #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: accepted bits collect in a queue; a full queue is a word.
    bit            q[$];
    logic [W-1:0]  m_data;
    logic          m_carry, m_valid, m_ferr, m_ovr;
    int            m_cnt;

    always @(posedge clk or posedge rst) begin : model
        int w;
        bit fe, oe, hand;
        if (rst) begin
            q.delete();
            m_data  = '0;
            m_carry = 1'b0;
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
            m_cnt   = 0;
        end else begin
            fe = 1'b0;
            oe = 1'b0;
            w  = -1;
            if (bus.bit_valid) begin
                if (bus.first) begin
                    fe = (q.size() != 0);
                    q.delete();
                    q.push_back(bus.bit_in);
                end else if (q.size() == 0) begin
                    fe = 1'b1;
                end else begin
                    q.push_back(bus.bit_in);
                end
            end
            if (q.size() == W) begin
                w = 0;
                for (int k = 0; k < W; k++) w += int'(q[k]) << k;
                q.delete();
            end
            hand = m_valid && bus.res_ready;
            if (hand) m_cnt = (m_cnt + 1) % (1 << CW);
            if (w >= 0) begin
                if (!m_valid || bus.res_ready) begin
                    m_data  = W'(w);
                    m_carry = bus.carry_in;
                    m_valid = 1'b1;
                end else begin
                    oe = 1'b1;
                end
            end else if (hand) begin
                m_valid = 1'b0;
            end
            m_ferr = fe | (m_ferr & !bus.clr_err);
            m_ovr  = oe | (m_ovr & !bus.clr_err);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_valid", 32'(bus.res_valid), 32'(m_valid));
            if (m_valid) begin
                chk("mon_data",  32'(bus.res_data),  32'(m_data));
                chk("mon_carry", 32'(bus.res_carry), 32'(m_carry));
            end
            chk("mon_busy",  32'(bus.busy),       32'(q.size() != 0));
            chk("mon_ferr",  32'(bus.frame_err),  32'(m_ferr));
            chk("mon_ovr",   32'(bus.overrun),    32'(m_ovr));
            chk("mon_count", 32'(bus.word_count), 32'(m_cnt));
        end
    end

    task automatic drv(input logic bv, input logic f, input logic b, input logic c,
                       input logic rdy, input logic clr);
        @(posedge clk);
        #2;
        bus.bit_valid = bv;
        bus.first     = f;
        bus.bit_in    = b;
        bus.carry_in  = c;
        bus.res_ready = rdy;
        bus.clr_err   = clr;
    endtask

    task automatic idle(input logic rdy, input logic clr = 1'b0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, rdy, clr);
    endtask

    task automatic send(input logic [W-1:0] w, input logic c, input logic rdy,
                        input logic rdy_last, input int bub);
        for (int k = 0; k < W; k++) begin
            drv(1'b1, k == 0, w[k], (k == W-1) ? c : 1'b0, (k == W-1) ? rdy_last : rdy, 1'b0);
            if (k == bub) idle(rdy);
        end
    endtask

    task automatic zero_inputs();
        bus.bit_valid = 1'b0;
        bus.first     = 1'b0;
        bus.bit_in    = 1'b0;
        bus.carry_in  = 1'b0;
        bus.res_ready = 1'b0;
        bus.clr_err   = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        zero_inputs();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  32'(bus.res_data),   32'h0);
        chk({tag, "_carry"}, 32'(bus.res_carry),  32'h0);
        chk({tag, "_valid"}, 32'(bus.res_valid),  32'h0);
        chk({tag, "_busy"},  32'(bus.busy),       32'h0);
        chk({tag, "_ferr"},  32'(bus.frame_err),  32'h0);
        chk({tag, "_ovr"},   32'(bus.overrun),    32'h0);
        chk({tag, "_count"}, 32'(bus.word_count), 32'h0);
    endtask

    initial begin
        zero_inputs();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk_all_zero("reset");
        mon_en = 1'b1;

        // Plain word 1,0,1,1 with carry
        send(4'b1101, 1'b1, 1'b1, 1'b1, -1);
        idle(1'b1);
        chk("t1_valid", 32'(bus.res_valid), 32'h1);
        chk("t1_data",  32'(bus.res_data),  32'hD);
        chk("t1_carry", 32'(bus.res_carry), 32'h1);
        chk("t1_ferr",  32'(bus.frame_err), 32'h0);
        chk("t1_ovr",   32'(bus.overrun),   32'h0);
        idle(1'b1);
        chk("t1_valid_drop", 32'(bus.res_valid),  32'h0);
        chk("t1_count",      32'(bus.word_count), 32'h1);

        // Same word with a bubble after bit 1
        do_reset();
        send(4'b1101, 1'b1, 1'b1, 1'b1, 1);
        chk("t2_busy_pre",  32'(bus.busy),      32'h1);
        chk("t2_valid_pre", 32'(bus.res_valid), 32'h0);
        idle(1'b1);
        chk("t2_data", 32'(bus.res_data), 32'hD);
        chk("t2_busy", 32'(bus.busy),     32'h0);

        // Overrun while the consumer stalls
        do_reset();
        send(4'h3, 1'b0, 1'b0, 1'b0, -1);
        send(4'hA, 1'b0, 1'b0, 1'b0, -1);
        idle(1'b0);
        chk("t3_data",  32'(bus.res_data),   32'h3);
        chk("t3_ovr",   32'(bus.overrun),    32'h1);
        chk("t3_count", 32'(bus.word_count), 32'h0);
        idle(1'b1);
        idle(1'b0);
        chk("t3_count_after", 32'(bus.word_count), 32'h1);
        chk("t3_valid_after", 32'(bus.res_valid),  32'h0);
        idle(1'b0, 1'b1);
        idle(1'b0);
        chk("t3_ovr_clr", 32'(bus.overrun), 32'h0);

        // Abort after two bits, then stray bit in IDLE
        do_reset();
        drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        send(4'b0110, 1'b0, 1'b1, 1'b1, -1);
        idle(1'b1);
        chk("t4_ferr", 32'(bus.frame_err), 32'h1);
        chk("t4_data", 32'(bus.res_data),  32'h6);
        idle(1'b1, 1'b1);
        idle(1'b1);
        chk("t4_ferr_clr", 32'(bus.frame_err), 32'h0);
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        chk("t4_stray", 32'(bus.frame_err), 32'h1);
        idle(1'b1, 1'b1);
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        chk("t4_event_wins", 32'(bus.frame_err), 32'h1);

        // Handoff and reload on the same edge
        do_reset();
        send(4'h5, 1'b0, 1'b0, 1'b0, -1);
        send(4'h9, 1'b1, 1'b0, 1'b1, -1);
        idle(1'b0);
        chk("t5_valid", 32'(bus.res_valid),  32'h1);
        chk("t5_data",  32'(bus.res_data),   32'h9);
        chk("t5_carry", 32'(bus.res_carry),  32'h1);
        chk("t5_ovr",   32'(bus.overrun),    32'h0);
        chk("t5_count", 32'(bus.word_count), 32'h1);

        // Counter wraps: five words with a 2-bit counter
        do_reset();
        for (int k = 1; k <= 5; k++) send(W'(k), 1'b0, 1'b1, 1'b1, -1);
        idle(1'b1);
        idle(1'b1);
        chk("t5_wrap", 32'(bus.word_count), 32'h1);

        // Asynchronous reset in the middle of a word
        do_reset();
        send(4'h7, 1'b1, 1'b0, 1'b0, -1);
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        zero_inputs();
        #1;
        chk_all_zero("t6_async");
        @(posedge clk);
        #2;
        rst = 1'b0;
        send(4'b1010, 1'b0, 1'b1, 1'b1, -1);
        idle(1'b1);
        chk("t6_data",  32'(bus.res_data),  32'hA);
        chk("t6_valid", 32'(bus.res_valid), 32'h1);
        chk("t6_ferr",  32'(bus.frame_err), 32'h0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drv($urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0, 1'($urandom),
                1'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
